// File: rtl/fp32_pkg.sv
// Shared constants and types for the FP32 multiplier normalize/round stage.
// Optional feature macro: FP_ROUND_RNE_EN (round-to-nearest-even; else truncate).
package fp32_pkg;

   // in_exp arrives already re-biased by the unpack stage.
   localparam int FP32_BIAS    = 127;
   localparam int FP32_EXP_MAX = 255;

   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

   localparam int WORD_W   = 32;
   localparam int FRAC_W   = 23;
   localparam int EXPF_W   = 8;
   localparam int EXP_IN_W = 10;
   localparam int EXP_W    = 11;
   localparam int MANT_W   = 48;
   localparam int SIGN_BIT = WORD_W - 1;

   localparam int FLAG_W   = 4;
   localparam int FLAG_OVF = 3;
   localparam int FLAG_UDF = 2;
   localparam int FLAG_INX = 1;
   localparam int FLAG_NAN = 0;

   typedef logic signed [EXP_W-1:0] exp_t;

   localparam exp_t EXP_OVF_LIM = exp_t'(FP32_EXP_MAX);
   localparam exp_t EXP_UDF_LIM = exp_t'(0);

   typedef struct packed {
      logic [WORD_W-1:0] result;
      logic [FLAG_W-1:0] flags;
   } res_t;

endpackage

// File: rtl/fp32_round.sv
// Combinational normalize, round and pack of a 48-bit significand product.
// Rounding is RNE when FP_ROUND_RNE_EN is defined, truncation otherwise.
module fp32_round
   import fp32_pkg::*;
(
   input  logic                sign,
   input  logic [EXP_IN_W-1:0] exp_in,
   input  logic [MANT_W-1:0]   mant,
   input  logic                nan,
   input  logic                inf,
   input  logic                zero,
   output res_t                res
);

   logic              hi;
   logic [MANT_W-2:0] norm;
   logic [FRAC_W-1:0] frac;
   logic              guard;
   logic              sticky;
   logic              inc;
   logic [FRAC_W:0]   sum;
   exp_t              exp_n;
   exp_t              exp_f;
   logic [WORD_W-1:0] sgn_w;

   // Align so the hidden bit sits just above the fraction, then round.
   always_comb begin
      hi     = mant[MANT_W-1];
      norm   = hi ? mant[MANT_W-2:0] : {mant[MANT_W-3:0], 1'b0};
      frac   = norm[MANT_W-2 -: FRAC_W];
      guard  = norm[MANT_W-2-FRAC_W];
      sticky = |norm[MANT_W-3-FRAC_W:0];
      exp_n  = $signed({exp_in[EXP_IN_W-1], exp_in})
             + $signed({{(EXP_W-1){1'b0}}, hi});
`ifdef FP_ROUND_RNE_EN
      inc    = guard & (sticky | frac[0]);
`else
      inc    = 1'b0;
`endif
      sum    = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
      exp_f  = exp_n + $signed({{(EXP_W-1){1'b0}}, sum[FRAC_W]});
   end

   // Pack with special-case and range priority.
   always_comb begin
      res   = '0;
      sgn_w = {sign, {SIGN_BIT{1'b0}}};
      if (nan) begin
         res.result          = FP32_QNAN;
         res.flags[FLAG_NAN] = 1'b1;
      end else if (inf) begin
         res.result = sgn_w | FP32_INF;
      end else if (zero) begin
         res.result = sgn_w;
      end else if (exp_f >= EXP_OVF_LIM) begin
         res.result          = sgn_w | FP32_INF;
         res.flags[FLAG_OVF] = 1'b1;
         res.flags[FLAG_INX] = 1'b1;
      end else if (exp_f <= EXP_UDF_LIM) begin
         res.result          = sgn_w;
         res.flags[FLAG_UDF] = 1'b1;
         res.flags[FLAG_INX] = 1'b1;
      end else begin
         res.result          = {sign, exp_f[EXPF_W-1:0], sum[FRAC_W-1:0]};
         res.flags[FLAG_INX] = guard | sticky;
      end
   end

endmodule

// File: rtl/fp32_mul_normalize.sv
// FP32 multiply back end: normalize/round/pack behind a valid/ready pipe.
// OUT_REG=1 adds an output register; FP_ROUND_RNE_EN selects RNE rounding.
module fp32_mul_normalize
   import fp32_pkg::*;
#(
   parameter int OUT_REG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sign,
   input  logic [EXP_IN_W-1:0] in_exp,
   input  logic [MANT_W-1:0]   in_mant,
   input  logic                in_nan,
   input  logic                in_inf,
   input  logic                in_zero,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORD_W-1:0]   out_result,
   output logic [FLAG_W-1:0]   out_flags
);

   res_t rnd;
   res_t s1_data;
   logic s1_valid;
   logic s1_adv;
   logic take;

   fp32_round u_round (
      .sign   (in_sign),
      .exp_in (in_exp),
      .mant   (in_mant),
      .nan    (in_nan),
      .inf    (in_inf),
      .zero   (in_zero),
      .res    (rnd)
   );

   assign in_ready = !s1_valid || s1_adv;
   assign take     = in_valid && in_ready;

   // Stage 1: capture the rounded result; drop valid once it moves on.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (take) begin
         s1_valid <= 1'b1;
         s1_data  <= rnd;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         res_t s2_data;
         logic s2_valid;
         logic s2_free;

         assign s2_free = !s2_valid || out_ready;
         assign s1_adv  = s1_valid && s2_free;

         // Stage 2: output register, holds while downstream stalls.
         always_ff @(posedge clk) begin
            if (rst) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
            end else if (s1_adv) begin
               s2_valid <= 1'b1;
               s2_data  <= s1_data;
            end else if (out_ready) begin
               s2_valid <= 1'b0;
            end
         end

         assign out_valid  = s2_valid;
         assign out_result = s2_data.result;
         assign out_flags  = s2_data.flags;
      end else begin : g_nreg
         assign s1_adv     = s1_valid && out_ready;
         assign out_valid  = s1_valid;
         assign out_result = s1_data.result;
         assign out_flags  = s1_data.flags;
      end
   endgenerate

endmodule

// File: doc/fp32_mul_normalize.md
FP32_MUL_NORMALIZE -- requirements
Module: fp32_mul_normalize

Interface
REQ-001 Parameter: OUT_REG, default 1, meaning 1 adds an output register stage (latency 2) and 0 drives outputs from stage 1 (latency 1).
REQ-002 clk  input  1  rising-edge clock; one clock; all state is clocked on clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream product valid.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 in_sign  input  1  sign of the product (sign_a XOR sign_b).
REQ-007 in_exp  input  10  signed biased exponent sum (ea + eb - 127).
REQ-008 in_mant  input  48  unsigned 24x24 significand product, in [2^46, 2^48) for normal operands.
REQ-009 in_nan, in_inf, in_zero  input  1 each  special-case flags from the unpack stage; in_nan has priority over in_inf, and in_inf over in_zero.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_result  output  32  packed FP32 result.
REQ-013 out_flags  output  4  {overflow, underflow, inexact, nan}.

Function
REQ-014 Transfer occurs on any cycle where valid and ready are both high; each accepted input produces exactly one output, in order.
REQ-015 in_ready SHALL be high when the stage-1 register is empty or is advancing in the same cycle; this gives full throughput of one transfer per cycle with no bubbles.
REQ-016 While out_valid=1 and out_ready=0, out_result and out_flags SHALL hold stable; stalled data SHALL NOT be lost or duplicated.
REQ-017 Normalize when in_mant[47]=1:
- exp = in_exp+1
- frac = in_mant[46:24]
- guard = in_mant[23]
- sticky = OR of in_mant[22:0]
REQ-018 Normalize when in_mant[47]=0:
- exp = in_exp
- frac = in_mant[45:23]
- guard = in_mant[22]
- sticky = OR of in_mant[21:0]
REQ-019 Round with the mode selected under Configuration.
- A rounding carry out of frac SHALL increment exp and clear frac.
REQ-020 Set inexact = guard OR sticky.
REQ-021 Final exp >= 255: output sign|0x7F800000, overflow=1, inexact=1.
REQ-022 Final exp <= 0: output signed zero, underflow=1, inexact=1. Subnormal results are flushed to zero.
REQ-023 Special-case outputs:
- in_nan: 0x7FC00000 with nan=1.
- in_inf: sign|0x7F800000, no flags.
- in_zero: sign|0x00000000, no flags.
- In all three cases in_mant and in_exp are ignored.
REQ-024 Exponent arithmetic SHALL be performed at 11-bit signed width, so that no wrap-around occurs for in_exp in the range [-512, 511].

Reset
REQ-025 With rst=1, all valid bits clear, out_valid=0, out_result=0, and out_flags=0 on the next edge; in_ready=1 the cycle after reset is released.
REQ-026 A reset asserted mid-operation discards all in-flight results; no output is produced for them.

Configuration
REQ-027 Macro FP_ROUND_RNE_EN: when defined, rounding is round-to-nearest-even, i.e. increment frac when guard AND (sticky OR frac[0]).
REQ-028 When FP_ROUND_RNE_EN is not defined, rounding is truncation: no increment. The inexact, overflow, and underflow rules are unchanged.

Structure
REQ-029 The shared package fp32_pkg SHALL hold the following, and no literal SHALL be repeated in the RTL:
- constants FP32_BIAS=127, FP32_EXP_MAX=255, FP32_QNAN=32'h7FC00000, FP32_INF=32'h7F800000;
- the flag bit indices.
REQ-030 The sub-module fp32_round holds the purely combinational normalize/round/pack logic. fp32_mul_normalize owns the pipeline registers and handshake.

Verification
REQ-031 in_exp=127, in_mant=0x900000000000, sign=0: expect result 0x40100000 (2.25), flags=0, output at latency 1+OUT_REG.
REQ-032 in_exp=127, in_mant=0x400000400000 (tie, lsb 0): expect 0x3F800000, inexact=1. Then in_mant=0x400000C00000: expect 0x3F800002 with RNE, or 0x3F800001 without FP_ROUND_RNE_EN.
REQ-033 in_exp=254, in_mant=0x900000000000: expect 0x7F800000, overflow=1, inexact=1. in_exp=-5, sign=1: expect 0x80000000, underflow=1.
REQ-034 in_nan=1 with in_inf=1: expect 0x7FC00000, nan=1. in_inf=1, sign=1: expect 0xFF800000.
REQ-035 Stream 8 back-to-back inputs while out_ready is held low for 3 cycles mid-stream: all 8 results arrive in order, none dropped, and outputs are stable while stalled.
REQ-036 Assert rst for 1 cycle with 2 results in flight: out_valid=0 next cycle, neither result emerges, and a new input is accepted the cycle after reset releases.
